// File: rtl/circuit_seq_ctrl_pkg.sv
// Shared types and constants for the resource-shared sequential datapath.
//   state_e    : controller state encoding (3 bits)
//   OP_ADD/SUB : operation select for the shared adder/subtractor
package circuit_seq_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ADD_D   = 3'd1,
        ADD_E   = 3'd2,
        SUB_CMP = 3'd3,
        SEL     = 3'd4,
        SHIFT   = 3'd5
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/circuit_seq_ctrl_addsub.sv
// Shared two's-complement adder/subtractor, purely combinational.
//   A, B : operands
//   op   : OP_ADD -> Y = A + B, OP_SUB -> Y = A - B
//   Y    : result, wraps modulo 2^DATAWIDTH
module shared_addsub
    import circuit_seq_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DW_DEFAULT
) (
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    input  logic                 op,
    output logic [DATAWIDTH-1:0] Y
);

    always_comb begin
        Y = (op == OP_SUB) ? (A - B) : (A + B);
    end

endmodule

// File: rtl/circuit_seq_ctrl.sv
// Multi-cycle controller computing z = (d==e ? a-b : g) >>> (d==e) and
// x = g << (d<e), with d = a+b, e = a+c, g = (d<e) ? e : d, using one
// shared adder/subtractor and one comparator.
//   Clk, Rst     : clock, async active-low reset
//   Start        : request, accepted only in IDLE
//   a, b, c      : signed operands, captured on the accepting edge
//   Busy         : high while a computation is in flight
//   Done         : one-cycle pulse when x and z update
//   x, z         : signed results, held between completions
module circuit_seq_ctrl
    import circuit_seq_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DW_DEFAULT
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        Busy,
    output logic                        Done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z
);

    state_e state_q, state_d;

    logic signed [DATAWIDTH-1:0] a_q, b_q, c_q;
    logic signed [DATAWIDTH-1:0] d_q, e_q, f_q, g_q, h_q;
    logic signed [DATAWIDTH-1:0] x_q, z_q;
    logic signed [DATAWIDTH-1:0] g_d, h_d;
    logic                        lt_q, eq_q;
    logic                        busy_q, done_q;

    logic                 op_c;
    logic                 bsel_c;
    logic                 ld_opnd_c, ld_d_c, ld_e_c, ld_cmp_c, ld_sel_c, ld_out_c;
    logic [DATAWIDTH-1:0] sum_c;

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: fixed one-cycle walk through the compute states
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = ADD_D;
            ADD_D:   state_d = ADD_E;
            ADD_E:   state_d = SUB_CMP;
            SUB_CMP: state_d = SEL;
            SEL:     state_d = SHIFT;
            SHIFT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        op_c      = OP_ADD;
        bsel_c    = 1'b0;
        ld_opnd_c = 1'b0;
        ld_d_c    = 1'b0;
        ld_e_c    = 1'b0;
        ld_cmp_c  = 1'b0;
        ld_sel_c  = 1'b0;
        ld_out_c  = 1'b0;
        case (state_q)
            IDLE:    ld_opnd_c = Start;
            ADD_D:   ld_d_c    = 1'b1;
            ADD_E:   begin ld_e_c = 1'b1; bsel_c = 1'b1; end
            SUB_CMP: begin ld_cmp_c = 1'b1; op_c = OP_SUB; end
            SEL:     ld_sel_c  = 1'b1;
            SHIFT:   ld_out_c  = 1'b1;
            default: ;
        endcase
    end

    // Shared unit: A is always a; B is c only while forming e
    shared_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
        .A  (a_q),
        .B  (bsel_c ? c_q : b_q),
        .op (op_c),
        .Y  (sum_c)
    );

    // h uses the g being registered in the same cycle
    always_comb begin
        g_d = lt_q ? e_q : d_q;
        h_d = eq_q ? f_q : g_d;
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            e_q    <= '0;
            f_q    <= '0;
            g_q    <= '0;
            h_q    <= '0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
            x_q    <= '0;
            z_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= ld_out_c;
            if (ld_opnd_c) begin
                a_q <= a;
                b_q <= b;
                c_q <= c;
            end
            if (ld_d_c) d_q <= sum_c;
            if (ld_e_c) e_q <= sum_c;
            if (ld_cmp_c) begin
                f_q  <= sum_c;
                lt_q <= (d_q < e_q);
                eq_q <= (d_q == e_q);
            end
            if (ld_sel_c) begin
                g_q <= g_d;
                h_q <= h_d;
            end
            if (ld_out_c) begin
                x_q <= g_q << lt_q;
                z_q <= h_q >>> eq_q;
            end
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign x    = x_q;
    assign z    = z_q;

endmodule

// File: tb/tb_circuit_seq_ctrl.sv
// Self-checking bench for circuit_seq_ctrl: timeline reference model plus
// directed literal cases, continuous-start, mid-flight reset and random traffic.
module tb_circuit_seq_ctrl;

    localparam int unsigned DW = 32;

    logic                 Clk;
    logic                 Rst;
    logic                 Start;
    logic signed [DW-1:0] a, b, c;
    logic                 Busy, Done;
    logic signed [DW-1:0] x, z;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    bit                   m_busy  = 1'b0;
    bit                   m_done  = 1'b0;
    int                   m_phase = 0;
    logic signed [DW-1:0] m_x = '0, m_z = '0, p_x = '0, p_z = '0;

    circuit_seq_ctrl #(.DATAWIDTH(DW)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .a     (a),
        .b     (b),
        .c     (c),
        .Busy  (Busy),
        .Done  (Done),
        .x     (x),
        .z     (z)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Results straight from the arithmetic definition
    function automatic void compute(input logic signed [DW-1:0] ia, input logic signed [DW-1:0] ib,
                                    input logic signed [DW-1:0] ic,
                                    output logic signed [DW-1:0] ox, output logic signed [DW-1:0] oz);
        logic signed [DW-1:0] d, e, g, h;
        d  = ia + ib;
        e  = ia + ic;
        g  = (d < e) ? e : d;
        ox = (d < e) ? (g + g) : g;
        h  = (d == e) ? (ia - ib) : g;
        oz = (d == e) ? (h >>> 1) : h;
    endfunction

    // Timeline model: accept when idle, results land 5 edges after acceptance
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_phase = 0;
            m_x     = '0;
            m_z     = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_phase++;
                if (m_phase == 5) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_x    = p_x;
                    m_z    = p_z;
                end
            end else if (Start) begin
                m_busy  = 1'b1;
                m_phase = 0;
                compute(a, b, c, p_x, p_z);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge Clk) begin
        if (chk_en && Rst) begin
            check("busy", 32'(Busy), 32'(m_busy));
            check("done", 32'(Done), 32'(m_done));
            check("x", x, m_x);
            check("z", z, m_z);
            check("busy_done_excl", 32'(Busy & Done), 32'd0);
        end
    end

    task automatic rand_operands();
        a = $urandom;
        b = $urandom;
        c = $urandom;
    endtask

    // Single request with literal expectations; DUT must be idle on entry
    task automatic run_one(input string name, input logic signed [DW-1:0] ia, input logic signed [DW-1:0] ib,
                           input logic signed [DW-1:0] ic, input logic signed [DW-1:0] ex,
                           input logic signed [DW-1:0] ez);
        logic signed [DW-1:0] mx, mz;
        int n;
        bit seen;
        compute(ia, ib, ic, mx, mz);
        check({name, "_model_x"}, mx, ex);
        check({name, "_model_z"}, mz, ez);
        @(negedge Clk);
        a = ia; b = ib; c = ic; Start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            Start = 1'b0;
            rand_operands();
            if (Done) seen = 1'b1;
        end
        check({name, "_latency"}, 32'(n), 32'd6);
        check({name, "_x"}, x, ex);
        check({name, "_z"}, z, ez);
    endtask

    initial begin
        int pulses;
        Rst = 1'b0; Start = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_x", x, 32'd0);
        check("rst_z", z, 32'd0);
        Rst = 1'b1;
        chk_en = 1'b1;

        run_one("t1", 32'sd5, 32'sd3, 32'sd1, 32'sd8, 32'sd8);
        run_one("t2", 32'sd1, 32'sd2, 32'sd5, 32'sd12, 32'sd6);
        run_one("t3", 32'sd4, 32'sd2, 32'sd2, 32'sd6, 32'sd1);
        run_one("t4", -32'sd8, 32'sd1, 32'sd1, -32'sd7, -32'sd5);
        run_one("t5", 32'h7FFF_FFFF, 32'sd1, 32'sd0, 32'hFFFF_FFFE, 32'h7FFF_FFFF);

        // Start held high: one result every 6 cycles, extra Starts ignored
        pulses = 0;
        @(negedge Clk);
        Start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            rand_operands();
            @(negedge Clk);
            if (Done) pulses++;
        end
        Start = 1'b0;
        check("cont_pulses", 32'(pulses), 32'd6);
        repeat (8) @(negedge Clk);

        // Reset while in SUB_CMP discards the computation
        a = 32'sd11; b = 32'sd22; c = 32'sd33; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_done", 32'(Done), 32'd0);
        check("rst_mid_x", x, 32'd0);
        check("rst_mid_z", z, 32'd0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Done) pulses++;
        end
        check("rst_no_done", 32'(pulses), 32'd0);
        run_one("after_rst", 32'sd1, 32'sd2, 32'sd5, 32'sd12, 32'sd6);

        // Random traffic with corner operands and occasional async reset
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            Start = ($urandom_range(2) == 0);
            case ($urandom_range(3))
                0: begin rand_operands(); c = b; end
                1: begin a = 32'h7FFF_FFFF; b = $urandom_range(3); c = $urandom_range(3); end
                2: begin a = 32'h8000_0000; b = -$signed(32'($urandom_range(3))); c = b; end
                default: rand_operands();
            endcase
            if ($urandom_range(120) == 0) begin
                #2 Rst = 1'b0;
                #1 Rst = 1'b1;
            end
        end
        Start = 1'b0;
        repeat (8) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circuit_seq_ctrl.md
# circuit_seq_ctrl

Multi-cycle, resource-shared implementation of the generated signed datapath: z = (dEQe ? a−b : g) >>> dEQe and x = g << dLTe, where d = a+b, e = a+c and g = dLTe ? e : d. One adder/subtractor and one comparator are time-multiplexed under a 6-state FSM with a Start/Busy/Done handshake. The block replaces the fully parallel netlist wherever area matters more than throughput.

## Interface
- DATAWIDTH, 32, width of operands, intermediates and results
- Clk  input  1  clock, all state updates on rising edge
- Rst  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only in IDLE
- a, b, c  input  DATAWIDTH each  signed operands; sampled on the accepting edge
- Busy  output  1  high while a computation is in flight
- Done  output  1  one-cycle pulse when x and z update
- x, z  output  DATAWIDTH each  signed results; hold between completions

## Operation
- States, in order: IDLE, ADD_D, ADD_E, SUB_CMP, SEL, SHIFT. Every non-IDLE state lasts exactly one cycle.
- IDLE with Start=1: latch a, b, c into operand registers, then go to ADD_D.
- ADD_D: shared unit computes d = a + b.
- ADD_E: shared unit computes e = a + c.
- SUB_CMP:
  - Shared unit computes f = a − b.
  - Comparator registers lt = (d < e), signed, and eq = (d == e).
- SEL: register g = lt ? e : d, then h = eq ? f : g.
  - h uses the g computed in the same cycle, combinationally.
- SHIFT:
  - x ← g << lt, a logical left shift by 0 or 1.
  - z ← h >>> eq, an arithmetic right shift by 0 or 1.
  - Done is registered to 1 and the FSM returns to IDLE.
- Arithmetic is two's complement modulo 2^DATAWIDTH. Overflow wraps silently and no flag is produced.
- Start while Busy=1 is ignored; it is neither queued nor latched.
- Operand changes after the accepting edge have no effect on the current computation.
- Async reset at any time:
  - State goes to IDLE.
  - Busy=0, Done=0, x=0, z=0.
  - All internal registers are cleared.
  - An in-flight computation is discarded.

## Timing
- Reset values: Busy=0, Done=0, x=0, z=0, state=IDLE.
- Start accepted at edge k:
  - Busy=1 from edge k through edge k+5.
  - x and z update at edge k+5.
  - Done=1 during the cycle after edge k+5 only.
- Busy deasserts at the same edge that Done asserts. They are never high together.
- During the Done cycle the FSM is in IDLE, so a Start then is accepted at edge k+6. Sustained throughput is one result per 6 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package circuit_seq_pkg holds:
  - State enum: IDLE=0, ADD_D=1, ADD_E=2, SUB_CMP=3, SEL=4, SHIFT=5, 3-bit encoding.
  - Shared-unit op constants: OP_ADD, OP_SUB.
- Sub-module shared_addsub(A, B, op, Y), parameterised on DATAWIDTH, purely combinational.
  - Operand selection: A=a in every state; B=b in ADD_D and SUB_CMP, B=c in ADD_E.
  - The FSM drives op.
- Comparator, muxes and shifters are inline in the top level.

## Test plan
- a=5, b=3, c=1, Start for 1 cycle -> Done pulse exactly 6 cycles after the accepting edge; x=8, z=8.
- a=1, b=2, c=5 -> lt=1, eq=0; x=12, z=6.
- a=4, b=2, c=2 -> eq=1, lt=0; x=6, z=1 (h=f=2, shifted right by 1).
- a=−8, b=1, c=1 -> d=e=−7, f=−9; x=−7, z=−5 (arithmetic shift of −9).
- a=0x7FFFFFFF, b=1, c=0 -> d wraps to 0x80000000, lt=1; x=0xFFFFFFFE, z=0x7FFFFFFF.
- Handshake and reset:
  - Start asserted continuously -> results every 6 cycles, and Start while Busy=1 is ignored.
  - Rst low for one cycle while the FSM is in SUB_CMP -> Busy=0, Done=0, x=z=0 immediately, no Done pulse follows.
  - A fresh Start after reset completes correctly.
